// File: rtl/brick_pkg.sv
// brick_pkg: shared geometry defaults, FSM states, level patterns and popcount
// for the brick_collider block.
package brick_pkg;
  localparam int DEF_COLS = 20;
  localparam int DEF_ROWS = 15;
  localparam int DEF_CELL_SHIFT = 5;
  localparam int DEF_BALL_R = 10;
  localparam int DEF_SCR_W = 640;
  localparam int DEF_SCR_H = 480;
  localparam int DEF_SLIDER_HW = 50;
  localparam int DEF_SLIDER_HH = 20;
  localparam int DEF_SCORE_W = 16;
  localparam int GRID = DEF_COLS * DEF_ROWS;
  typedef enum logic [2:0] {IDLE, PROBE_L, PROBE_R, PROBE_U, PROBE_D, REPORT} state_e;
  // level 0: rows 1-4 full; level 1: rows 2-3 full; level 2: rows 0 and 5 full
  localparam logic [GRID-1:0] LEVEL0 = {200'b0, {80{1'b1}}, 20'b0};
  localparam logic [GRID-1:0] LEVEL1 = {220'b0, {40{1'b1}}, 40'b0};
  localparam logic [GRID-1:0] LEVEL2 = {180'b0, {20{1'b1}}, 80'b0, {20{1'b1}}};
  function automatic int popcount(input logic [GRID-1:0] v);
    popcount = 0;
    for (int i = 0; i < GRID; i++) popcount += int'(v[i]);
  endfunction
endpackage

// File: rtl/brick_probe.sv
// brick_probe: maps a signed 11-bit probe point to a grid cell index and
// flags whether that cell lies inside the grid.
module brick_probe #(
  parameter int COLS = 20,
  parameter int ROWS = 15,
  parameter int CELL_SHIFT = 5
) (
  input  logic [10:0]                     px_i,
  input  logic [10:0]                     py_i,
  output logic [$clog2(COLS*ROWS)-1:0]    idx_o,
  output logic                            in_range_o
);
  logic [10:0] col, row;
  assign col = px_i >> CELL_SHIFT;
  assign row = py_i >> CELL_SHIFT;
  assign in_range_o = !px_i[10] && !py_i[10] && int'(col) < COLS && int'(row) < ROWS;
  assign idx_o = ($clog2(COLS*ROWS))'(int'(col) + int'(row) * COLS);
endmodule

// File: rtl/brick_collider.sv
// brick_collider: probes the four sides of a latched ball position against the
// brick grid, walls and slider, clearing and scoring hit bricks one probe per cycle.
module brick_collider import brick_pkg::*; #(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS,
  parameter int CELL_SHIFT = DEF_CELL_SHIFT,
  parameter int BALL_R = DEF_BALL_R,
  parameter int SCR_W = DEF_SCR_W,
  parameter int SCR_H = DEF_SCR_H,
  parameter int SLIDER_HW = DEF_SLIDER_HW,
  parameter int SLIDER_HH = DEF_SLIDER_HH,
  parameter int SCORE_W = DEF_SCORE_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [1:0]                       iLevel,
  input  logic                             iLoad,
  input  logic                             iTick,
  input  logic [9:0]                       iBall_x,
  input  logic [9:0]                       iBall_y,
  input  logic [9:0]                       iSlider_x,
  input  logic [9:0]                       iSlider_y,
  output logic [COLS*ROWS-1:0]             oState_flag,
  output logic [3:0]                       oCrash,
  output logic                             oCrash_valid,
  output logic                             oBallDie,
  output logic [SCORE_W-1:0]               oScore,
  output logic [$clog2(COLS*ROWS+1)-1:0]   oBlocks_left,
  output logic                             oLevel_clear,
  output logic                             oBusy
);
  localparam int N = COLS * ROWS;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0] PAT0 = N'(LEVEL0);
  localparam logic [N-1:0] PAT1 = N'(LEVEL1);
  localparam logic [N-1:0] PAT2 = N'(LEVEL2);
  localparam int CNT0 = popcount(GRID'(PAT0));
  localparam int CNT1 = popcount(GRID'(PAT1));
  localparam int CNT2 = popcount(GRID'(PAT2));
  state_e state_q;
  logic [N-1:0] flag_q, load_pat;
  logic [CW-1:0] left_q, load_cnt;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0] crash_q, wall;
  logic [2:0] hits_q;
  logic valid_q, die_q, in_range, hit, slider;
  logic [9:0] bx_q, by_q, sx_q, sy_q;
  logic [10:0] px, py;
  logic [IW-1:0] idx;
  int bx, by, sx, sy;
  assign bx = int'(bx_q);
  assign by = int'(by_q);
  assign sx = int'(sx_q);
  assign sy = int'(sy_q);
  assign px = 11'(state_q == PROBE_L ? bx - BALL_R - 1 : state_q == PROBE_R ? bx + BALL_R + 1 : bx);
  assign py = 11'(state_q == PROBE_U ? by - BALL_R - 1 : state_q == PROBE_D ? by + BALL_R + 1 : by);
  brick_probe #(.COLS(COLS), .ROWS(ROWS), .CELL_SHIFT(CELL_SHIFT)) u_probe (
    .px_i(px), .py_i(py), .idx_o(idx), .in_range_o(in_range)
  );
  assign hit = state_q inside {PROBE_L, PROBE_R, PROBE_U, PROBE_D} && in_range && flag_q[idx];
  // slider top edge is a 3-px catch window so a fast ball still registers
  assign slider = by + BALL_R >= sy - SLIDER_HH && by + BALL_R <= sy - SLIDER_HH + 2 &&
                  bx + BALL_R - 1 >= sx - SLIDER_HW && bx - BALL_R + 1 <= sx + SLIDER_HW;
  assign wall = {bx <= BALL_R, bx >= SCR_W - BALL_R, by <= BALL_R, slider};
  assign score_d = &score_q ? score_q : score_q + 1'b1;
  assign load_pat = iLevel == 2'd0 ? PAT0 : iLevel == 2'd1 ? PAT1 : PAT2;
  assign load_cnt = iLevel == 2'd0 ? CW'(CNT0) : iLevel == 2'd1 ? CW'(CNT1) : CW'(CNT2);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      flag_q <= PAT0;
      left_q <= CW'(CNT0);
      score_q <= '0;
      crash_q <= '0;
      hits_q <= '0;
      valid_q <= 1'b0;
      die_q <= 1'b0;
      bx_q <= '0;
      by_q <= '0;
      sx_q <= '0;
      sy_q <= '0;
    end else if (iLoad) begin
      state_q <= IDLE;
      flag_q <= load_pat;
      left_q <= load_cnt;
      valid_q <= 1'b0;
    end else begin
      valid_q <= state_q == PROBE_D;
      if (hit) begin
        flag_q[idx] <= 1'b0;
        left_q <= left_q - 1'b1;
        score_q <= score_d;
      end
      if (state_q inside {PROBE_L, PROBE_R, PROBE_U}) hits_q <= {hits_q[1:0], hit};
      if (state_q == PROBE_D) begin
        crash_q <= {hits_q, hit} | wall;
        die_q <= by > SCR_H - BALL_R;
      end
      if (state_q == IDLE && iTick) begin
        bx_q <= iBall_x;
        by_q <= iBall_y;
        sx_q <= iSlider_x;
        sy_q <= iSlider_y;
      end
      state_q <= state_q == IDLE ? (iTick ? PROBE_L : IDLE) :
                 state_q == REPORT ? IDLE : state_e'(state_q + 3'd1);
    end
  end
  assign oState_flag = flag_q;
  assign oCrash = crash_q;
  assign oCrash_valid = valid_q;
  assign oBallDie = die_q;
  assign oScore = score_q;
  assign oBlocks_left = left_q;
  assign oLevel_clear = left_q == '0;
  assign oBusy = state_q != IDLE;
endmodule

// File: tb/tb_brick_collider.sv
// tb_brick_collider: directed ticks with hand-computed results; a monitor pops
// the expected report from a scoreboard queue on every oCrash_valid.
module tb_brick_collider;
  localparam logic [299:0] L0 = {200'b0, {80{1'b1}}, 20'b0};
  localparam logic [299:0] L1 = {220'b0, {40{1'b1}}, 40'b0};
  localparam logic [299:0] L2 = {180'b0, {20{1'b1}}, 80'b0, {20{1'b1}}};
  typedef struct {
    logic [3:0] c;
    logic d;
    int s;
    int l;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  logic clk = 1'b0, rst = 1'b1, iLoad = 1'b0, iTick = 1'b0;
  logic [1:0] iLevel = 2'd0;
  logic [9:0] iBall_x = '0, iBall_y = '0, iSlider_x = '0, iSlider_y = '0;
  logic [299:0] oState_flag, f4;
  logic [3:0] oCrash, c4;
  logic oCrash_valid, oBallDie, oLevel_clear, oBusy, v4, d4, lc4, b4;
  logic [15:0] oScore;
  logic [3:0] s4;
  logic [8:0] oBlocks_left, l4;
  logic [299:0] ef;
  int k;
  brick_collider dut (
    .clk(clk), .rst(rst), .iLevel(iLevel), .iLoad(iLoad), .iTick(iTick),
    .iBall_x(iBall_x), .iBall_y(iBall_y), .iSlider_x(iSlider_x), .iSlider_y(iSlider_y),
    .oState_flag(oState_flag), .oCrash(oCrash), .oCrash_valid(oCrash_valid), .oBallDie(oBallDie),
    .oScore(oScore), .oBlocks_left(oBlocks_left), .oLevel_clear(oLevel_clear), .oBusy(oBusy)
  );
  brick_collider #(.SCORE_W(4)) dut4 (
    .clk(clk), .rst(rst), .iLevel(iLevel), .iLoad(iLoad), .iTick(iTick),
    .iBall_x(iBall_x), .iBall_y(iBall_y), .iSlider_x(iSlider_x), .iSlider_y(iSlider_y),
    .oState_flag(f4), .oCrash(c4), .oCrash_valid(v4), .oBallDie(d4),
    .oScore(s4), .oBlocks_left(l4), .oLevel_clear(lc4), .oBusy(b4)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [299:0] a, input logic [299:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (oCrash_valid) begin
      chk("report_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("crash", oCrash, e.c);
        chk("ball_die", oBallDie, e.d);
        chk("score", oScore, e.s);
        chk("blocks_left", oBlocks_left, e.l);
      end
    end
  end
  task automatic do_reset();
    rst = 1'b1;
    iLoad = 1'b0;
    iTick = 1'b0;
    @(negedge clk);
    chk("rst_flags", oState_flag, L0);
    chk("rst_left", oBlocks_left, 80);
    chk("rst_score", oScore, 0);
    chk("rst_crash", oCrash, 0);
    chk("rst_valid", oCrash_valid, 0);
    chk("rst_die", oBallDie, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_clear", oLevel_clear, 0);
    rst = 1'b0;
  endtask
  task automatic tick(input int bx, input int by, input int sx, input int sy, input logic [3:0] c,
                      input logic d, input int sc, input int lf, input bit spam);
    sb.push_back('{c, d, sc, lf});
    iBall_x = 10'(bx);
    iBall_y = 10'(by);
    iSlider_x = 10'(sx);
    iSlider_y = 10'(sy);
    iTick = 1'b1;
    @(negedge clk);
    for (int j = 1; j <= 5; j++) begin
      chk($sformatf("valid_cycle%0d", j), oCrash_valid, j == 5);
      chk($sformatf("busy_cycle%0d", j), oBusy, 1);
      iTick = spam && j < 5;
      @(negedge clk);
    end
    iTick = 1'b0;
    chk("busy_after", oBusy, 0);
  endtask
  initial begin
    do_reset();
    tick(100, 170, 0, 0, 4'b0010, 1'b0, 1, 79, 0);
    ef = L0;
    ef[83] = 1'b0;
    chk("flags_bit83", oState_flag, ef);
    do_reset();
    tick(100, 140, 0, 0, 4'b1100, 1'b0, 2, 78, 0);
    ef[82] = 1'b0;
    chk("flags_bit82_83", oState_flag, ef);
    tick(10, 300, 0, 0, 4'b1000, 1'b0, 2, 78, 0);
    chk("flags_wall_unchanged", oState_flag, ef);
    tick(320, 455, 320, 485, 4'b0001, 1'b0, 2, 78, 0);
    tick(320, 471, 0, 0, 4'b0000, 1'b1, 2, 78, 1);
    iBall_x = 10'd320;
    iBall_y = 10'd300;
    iTick = 1'b1;
    @(negedge clk);
    iTick = 1'b0;
    @(negedge clk);
    iLevel = 2'd1;
    iLoad = 1'b1;
    @(negedge clk);
    iLoad = 1'b0;
    chk("abort_busy", oBusy, 0);
    chk("load1_flags", oState_flag, L1);
    chk("load1_left", oBlocks_left, 40);
    chk("load1_score", oScore, 2);
    repeat (6) @(negedge clk);
    iLevel = 2'd3;
    iLoad = 1'b1;
    iTick = 1'b1;
    @(negedge clk);
    iLoad = 1'b0;
    iTick = 1'b0;
    chk("load_tick_busy", oBusy, 0);
    chk("load3_flags", oState_flag, L2);
    chk("load3_left", oBlocks_left, 40);
    repeat (7) @(negedge clk);
    do_reset();
    k = 0;
    for (int r = 4; r >= 1; r--)
      for (int c = 0; c < 20; c++) begin
        k++;
        tick(c * 32 + 16, r * 32 + 37, 0, 0, 4'b0010, 1'b0, k, 80 - k, 0);
      end
    chk("clear_flag", oLevel_clear, 1);
    chk("clear_left", oBlocks_left, 0);
    chk("clear_flags", oState_flag, 0);
    chk("score80", oScore, 80);
    chk("score_sat4", s4, 15);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
